// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire stage: default widths, op-codes and FSM encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 4;
   localparam int ALU_OP_W  = 2;

   localparam logic [ALU_OP_W-1:0] ALU_OP_ADD = 2'b00;
   localparam logic [ALU_OP_W-1:0] ALU_OP_SUB = 2'b01;
   localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 2'b10;
   localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command and result handshakes of the ALU issue stage; master is the upstream/consumer side,
// slave is the stage itself.
interface alu_issue_stage_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OP_W  = ALU_OP_W
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [OP_W-1:0]  cmd_op;
   logic             cmd_acc;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_zero;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, res_ready,
      input  cmd_ready, res_valid, res_data, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_acc, res_ready,
      output cmd_ready, res_valid, res_data, res_zero
   );

endinterface

// File: rtl/alu_issue_stage.sv
// Issue/retire stage around an external combinational ALU: IDLE -> EXEC -> DONE.
// Define ALU_ISSUE_OVERLAP_EN to let DONE accept the next command while the result retires.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OP_W  = ALU_OP_W
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   alu_issue_stage_if.slave bus,
   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [OP_W-1:0]  alu_ctrl_o,
   input  logic [WIDTH-1:0] alu_r_i
);

   state_e           state_q, state_d;
   logic             accept, capture;
   logic             cmd_ready, res_valid;
   logic [WIDTH-1:0] a_q, b_q;
   logic [OP_W-1:0]  ctrl_q;
   logic [WIDTH-1:0] acc_q;
   logic             zero_q;
   logic [WIDTH-1:0] a_d;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            capture = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
`ifdef ALU_ISSUE_OVERLAP_EN
            cmd_ready = bus.res_ready;
            if (bus.res_ready && bus.cmd_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end else if (bus.res_ready) begin
               state_d = IDLE;
            end
`else
            if (bus.res_ready) state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // The accumulator doubles as the result register; in DONE it already holds the retiring value.
   assign a_d = bus.cmd_acc ? acc_q : bus.cmd_a;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // NOTE: every register here is reset explicitly; the zero flag resets to 1 to match a zero result.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         a_q    <= '0;
         b_q    <= '0;
         ctrl_q <= '0;
         acc_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         if (accept) begin
            a_q    <= a_d;
            b_q    <= bus.cmd_b;
            ctrl_q <= bus.cmd_op;
         end
         if (capture) begin
            acc_q  <= alu_r_i;
            zero_q <= (alu_r_i == '0);
         end
      end
   end

   assign alu_a_o       = a_q;
   assign alu_b_o       = b_q;
   assign alu_ctrl_o    = ctrl_q;
   assign bus.cmd_ready = cmd_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = acc_q;
   assign bus.res_zero  = zero_q;

endmodule
